// File: rtl/prod_accumulator_pkg.sv
// Shared definitions for the product accumulator slice.
//   state_t     : frame FSM state (ACCUM collects terms, HOLD presents the result)
//   PROD_W_DEF  : product width, matches the 4x4 array multiplier output
//   ACC_W_DEF   : accumulator width; holds 4*225=900 without saturating
//   ACC_MAX     : saturation ceiling for the default accumulator width
package prod_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int unsigned PROD_W_DEF = 8;
  localparam int unsigned ACC_W_DEF  = 12;
  localparam int unsigned ACC_MAX    = (1 << ACC_W_DEF) - 1;

endpackage

// File: rtl/prod_accumulator_sat_adder.sv
// Combinational saturating adder: sum = min(a + b, 2^ACC_W-1).
//   a         in  ACC_W   running accumulator value
//   b         in  PROD_W  unsigned product to add
//   sum       out ACC_W   clamped sum
//   clamp_hit out 1       the true sum exceeded the accumulator range
// Assumes PROD_W <= ACC_W.
module sat_adder #(
  parameter int unsigned ACC_W  = 12,
  parameter int unsigned PROD_W = 8
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              clamp_hit
);

  logic [ACC_W:0] wide;

  assign wide      = {1'b0, a} + (ACC_W+1)'(b);
  assign clamp_hit = wide[ACC_W];
  assign sum       = clamp_hit ? '1 : wide[ACC_W-1:0];

endmodule

// File: rtl/prod_accumulator.sv
// Dot-product accumulator downstream of the 4x4 array multiplier.
// Sums up to N_TERMS unsigned products per frame (fewer if in_last ends the
// frame early) and presents one saturated sum per frame, held under
// backpressure.
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               synchronous frame abort (highest priority)
//   in_valid/in_ready   product stream handshake; in_prod, in_last qualified by it
//   out_valid/out_ready result handshake
//   out_sum             saturated frame sum
//   out_cnt             number of terms in out_sum (1..N_TERMS)
//   out_ovf             saturation occurred in this frame
module prod_accumulator
  import prod_acc_pkg::*;
#(
  parameter int unsigned PROD_W  = PROD_W_DEF,
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned CNT_W   = $clog2(N_TERMS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_ovf
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;

  logic [ACC_W-1:0]   acc_base;
  logic [ACC_W-1:0]   sum;
  logic               clamp_hit;
  logic               ovf_new;
  logic               hs;
  logic               frame_end;
  logic [CNT_W-1:0]   cnt_inc;

  assign in_ready  = (state == ACCUM);
  // out_valid is the state flop itself (1-bit enum), so it stays registered.
  assign out_valid = (state == HOLD);

  assign hs        = in_valid & in_ready;
  // A fresh frame starts from zero, so no pre-clear cycle is needed.
  assign acc_base  = (cnt == '0) ? '0 : acc;
  assign ovf_new   = ((cnt == '0) ? 1'b0 : ovf) | clamp_hit;
  assign cnt_inc   = cnt + CNT_W'(1);
  assign frame_end = hs & (in_last | (cnt == LAST_CNT));

  sat_adder #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_sat_adder (
    .a         (acc_base),
    .b         (in_prod),
    .sum       (sum),
    .clamp_hit (clamp_hit)
  );

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ACCUM;
    end else begin
      unique case (state)
        ACCUM: if (frame_end) state_nxt = HOLD;
        HOLD:  if (out_ready) state_nxt = ACCUM;
        default: state_nxt = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      out_sum <= '0;
      out_cnt <= '0;
      out_ovf <= 1'b0;
    end else if (clear) begin
      // Results already presented are kept; only the frame in progress is dropped.
      cnt <= '0;
    end else if (hs) begin
      acc <= sum;
      cnt <= cnt_inc;
      ovf <= ovf_new;
      if (frame_end) begin
        out_sum <= sum;
        out_cnt <= cnt_inc;
        out_ovf <= ovf_new;
      end
    end else if ((state == HOLD) && out_ready) begin
      cnt <= '0;
    end
  end

endmodule

// File: tb/tb_prod_accumulator.sv
module tb_prod_accumulator;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_prod;
  logic       in_last;
  logic       out_ready;

  logic        in_ready_a, out_valid_a, out_ovf_a;
  logic [11:0] out_sum_a;
  logic [2:0]  out_cnt_a;
  logic        in_ready_b, out_valid_b, out_ovf_b;
  logic [8:0]  out_sum_b;
  logic [2:0]  out_cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected result of the frame most recently completed (from the model)
  int q_terms[$];
  int e_sum12, e_sum9, e_cnt, e_ovf12, e_ovf9;

  always #5 clk = ~clk;

  prod_accumulator dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_sum(out_sum_a), .out_cnt(out_cnt_a), .out_ovf(out_ovf_a)
  );

  prod_accumulator #(.ACC_W(9)) dut9 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sum(out_sum_b), .out_cnt(out_cnt_b), .out_ovf(out_ovf_b)
  );

  typedef struct {
    int t0, t1, t2, t3;
    int n;
    int sum12, ovf12, sum9, ovf9;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: sums are monotone, so saturation is simply total > max.
  task automatic model_finish();
    int total;
    total = 0;
    foreach (q_terms[i]) total += q_terms[i];
    e_cnt   = q_terms.size();
    e_sum12 = (total > 4095) ? 4095 : total;
    e_ovf12 = (total > 4095) ? 1 : 0;
    e_sum9  = (total > 511) ? 511 : total;
    e_ovf9  = (total > 511) ? 1 : 0;
    q_terms.delete();
  endtask

  // Present one term and wait (bounded) for the handshake. Returns 1 if frame ended.
  task automatic send(input int prod, input bit last, output bit done);
    int guard;
    in_valid = 1'b1;
    in_prod  = prod[7:0];
    in_last  = last;
    guard = 0;
    while (!in_ready_a && guard < 20) begin
      tick();
      guard++;
    end
    if (!in_ready_a) chk("in_ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    q_terms.push_back(prod);
    done = last || (q_terms.size() == N);
    if (done) model_finish();
  endtask

  task automatic check_out(input string tag, input int s12, input int s9,
                           input int c, input int o12, input int o9);
    chk({tag, "_valid"},   out_valid_a, 1);
    chk({tag, "_valid9"},  out_valid_b, 1);
    chk({tag, "_inrdy"},   in_ready_a, 0);
    chk({tag, "_sum"},     out_sum_a, s12);
    chk({tag, "_sum9"},    out_sum_b, s9);
    chk({tag, "_cnt"},     out_cnt_a, c);
    chk({tag, "_cnt9"},    out_cnt_b, c);
    chk({tag, "_ovf"},     out_ovf_a, o12);
    chk({tag, "_ovf9"},    out_ovf_b, o9);
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drop_valid"}, out_valid_a, 0);
    chk({tag, "_rdy_again"},  in_ready_b, 1);
  endtask

  task automatic send_frame(input int a, input int b, input int c, input int d, input int n);
    int t[4];
    bit done;
    t[0] = a; t[1] = b; t[2] = c; t[3] = d;
    for (int i = 0; i < n; i++) send(t[i], (i == n - 1) && (n < N), done);
    if (!done) chk("frame_not_closed", 0, 1);
  endtask

  initial begin
    bit done;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;

    vecs[0] = '{15, 225, 100, 1, 4, 341, 0, 341, 0};
    vecs[1] = '{1, 1, 1, 1, 4, 4, 0, 4, 0};
    vecs[2] = '{10, 20, 0, 0, 2, 30, 0, 30, 0};
    vecs[3] = '{225, 225, 100, 50, 4, 600, 0, 511, 1};
    vecs[4] = '{1, 1, 1, 1, 4, 4, 0, 4, 0};
    vecs[5] = '{225, 225, 225, 225, 4, 900, 0, 511, 1};
    vecs[6] = '{200, 0, 0, 0, 1, 200, 0, 200, 0};

    #3;
    chk("rst_valid", out_valid_a, 0);
    chk("rst_ready", in_ready_a, 1);
    chk("rst_sum",   out_sum_a, 0);
    chk("rst_cnt",   out_cnt_a, 0);
    chk("rst_ovf",   out_ovf_b, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Table-driven frames (T1, T3, T4 and the frames that follow them)
    foreach (vecs[i]) begin
      send_frame(vecs[i].t0, vecs[i].t1, vecs[i].t2, vecs[i].t3, vecs[i].n);
      check_out($sformatf("vec%0d", i), vecs[i].sum12, vecs[i].sum9, vecs[i].n,
                vecs[i].ovf12, vecs[i].ovf9);
      if (i == 0) begin
        // Backpressure: result held, presented term ignored
        in_valid = 1'b1; in_prod = 8'd7;
        for (int k = 0; k < 5; k++) begin
          tick();
          check_out("bp", 341, 341, 4, 0, 0);
        end
        in_valid = 1'b0;
      end
      accept($sformatf("vec%0d", i));
    end

    // Early end with gaps between terms
    send(10, 1'b0, done);
    repeat (3) tick();
    chk("gap_no_valid", out_valid_a, 0);
    send(20, 1'b1, done);
    check_out("gap", 30, 30, 2, 0, 0);
    accept("gap");

    // Clear mid-frame with a term presented in the same cycle
    send(2, 1'b0, done);
    send(2, 1'b0, done);
    in_valid = 1'b1; in_prod = 8'd9; clear = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    q_terms.delete();
    chk("clr_valid", out_valid_a, 0);
    chk("clr_keep_sum", out_sum_a, 30);
    send_frame(3, 3, 3, 3, 4);
    check_out("clr", 12, 12, 4, 0, 0);

    // Clear while holding a result: valid drops, result registers kept
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clrhold_valid", out_valid_a, 0);
    chk("clrhold_ready", in_ready_a, 1);
    chk("clrhold_sum", out_sum_a, 12);
    chk("clrhold_cnt", out_cnt_a, 4);

    // Asynchronous reset while holding
    send_frame(50, 60, 0, 0, 2);
    check_out("prerst", 110, 110, 2, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid_a, 0);
    chk("arst_sum", out_sum_a, 0);
    chk("arst_sum9", out_sum_b, 0);
    chk("arst_cnt", out_cnt_a, 0);
    chk("arst_ready", in_ready_a, 1);
    #3 rst_n = 1'b1;
    tick();
    send_frame(225, 225, 225, 225, 4);
    check_out("postrst", 900, 511, 4, 0, 1);
    accept("postrst");

    // Randomized frames against the reference model
    for (int f = 0; f < 150; f++) begin
      int len;
      len = $urandom_range(1, N);
      if ($urandom_range(0, 9) == 0 && len > 1) begin
        // Abort part-way through
        for (int k = 0; k < len - 1; k++) send($urandom_range(0, 225), 1'b0, done);
        clear = 1'b1; in_valid = $urandom_range(0, 1); in_prod = 8'($urandom_range(0, 225));
        tick();
        clear = 1'b0; in_valid = 1'b0;
        q_terms.delete();
        chk("rnd_clr_valid", out_valid_a, 0);
        continue;
      end
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) tick();
        send($urandom_range(0, 255), (k == len - 1) && ($urandom_range(0, 1) == 1), done);
        if (done) break;
      end
      if (!done) begin
        // Length reached without in_last chosen: finish with in_last
        while (!done) send($urandom_range(0, 255), 1'b1, done);
      end
      check_out("rnd", e_sum12, e_sum9, e_cnt, e_ovf12, e_ovf9);
      repeat ($urandom_range(0, 3)) begin
        in_valid = $urandom_range(0, 1); in_prod = 8'($urandom_range(0, 255));
        tick();
        chk("rnd_hold_sum", out_sum_a, e_sum12);
        chk("rnd_hold_valid", out_valid_b, 1);
      end
      in_valid = 1'b0;
      accept("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
